// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial adder sequencer.
// The upstream producer and downstream consumer both sit on the master side.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial addition sequencer wrapped around an external single-bit
// full-adder cell. Operands are presented LSB-first, one bit per clock;
// the carry lives in a flip-flop between bits. The assembled sum and
// carry-out are offered downstream over a valid/ready handshake.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_adder_ctrl_if.slave   bus,
    output logic                 fa_a,
    output logic                 fa_b,
    output logic                 fa_ci,
    input  logic                 fa_s,
    input  logic                 fa_cout,
    output logic                 busy
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_out_valid;

    logic             w_shift;
    logic             w_last;
    logic             w_in_ready;
    logic             w_accept;
    logic [WIDTH:0]   w_sum_cat;
    logic [WIDTH-1:0] w_sum_next;

    assign w_shift = (r_state == ST_SHIFT);
    assign w_last  = w_shift && (r_cnt == LAST_CNT);

    // A new operand set may enter from IDLE, or from DONE on the same edge
    // the current result is consumed. Held low throughout reset.
    assign w_in_ready = !rst && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_DONE) && bus.out_ready));
    assign w_accept   = bus.in_valid && w_in_ready;

    // New sum bit enters at the MSB; slicing the concatenation keeps this
    // valid for WIDTH == 1, where the old shift register contributes nothing.
    assign w_sum_cat  = {fa_s, r_sum_sh};
    assign w_sum_next = w_sum_cat[WIDTH:1];

    // Full-adder inputs are quiet outside SHIFT.
    assign fa_a  = w_shift & r_a_sh[0];
    assign fa_b  = w_shift & r_b_sh[0];
    assign fa_ci = w_shift & r_carry;
    assign busy  = w_shift;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;

    // Sequencer: operand load, bit-serial shift, result hand-off.
    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order below.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_sum_sh <= w_sum_next;
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_carry  <= fa_cout;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_sum       <= w_sum_next;
                        r_cout      <= fa_cout;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // An accepted operand set overrides the case above: from IDLE,
            // or straight from DONE when the result is taken on this edge.
            if (w_accept) begin
                r_a_sh  <= bus.a;
                r_b_sh  <= bus.b;
                r_carry <= bus.cin;
                r_cnt   <= '0;
                r_state <= ST_SHIFT;
            end
        end
    end
endmodule
